// File: rtl/seq_1010_tx.sv
// seq_1010_tx: serial frame transmitter (sync 1010, MSB-first payload, even parity, gap bit)
module seq_1010_tx #(
    parameter int BIT_CYCLES = 1,
    parameter int DATA_W     = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out,
    output logic              tx_active,
    output logic              bit_strobe,
    output logic              frame_done
);
    typedef enum logic [2:0] {S_IDLE, S_SYNC, S_DATA, S_PARITY, S_GAP} state_t;
    state_t            r_state;
    logic [7:0]        r_cnt;
    logic [5:0]        r_bit;
    logic [DATA_W-1:0] r_shift;
    logic              r_par;
    logic              r_out;
    logic              r_active;
    logic              r_strobe;
    logic              r_done;
    logic              r_ready;
    logic              w_last;
    logic [DATA_W-1:0] w_shl;
    assign w_last     = r_cnt == 8'(BIT_CYCLES - 1);
    assign w_shl      = r_shift << 1;
    assign in_ready   = r_ready;
    assign out        = r_out;
    assign tx_active  = r_active;
    assign bit_strobe = r_strobe;
    assign frame_done = r_done;
    // frame FSM: outputs are set on the edge that enters each bit so they line up with the state
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_bit    <= '0;
            r_shift  <= '0;
            r_par    <= 1'b0;
            r_out    <= 1'b0;
            r_active <= 1'b0;
            r_strobe <= 1'b0;
            r_done   <= 1'b0;
            r_ready  <= 1'b0;
        end else if (r_state == S_IDLE) begin
            r_strobe <= 1'b0;
            r_done   <= 1'b0;
            r_ready  <= 1'b1;
            if (in_valid && r_ready) begin
                r_state  <= S_SYNC;
                r_shift  <= in_data;
                r_par    <= ^in_data;
                r_cnt    <= '0;
                r_bit    <= '0;
                r_out    <= 1'b1;
                r_active <= 1'b1;
                r_strobe <= 1'b1;
                r_ready  <= 1'b0;
            end
        end else if (!w_last) begin
            r_cnt    <= r_cnt + 8'd1;
            r_strobe <= 1'b0;
            r_done   <= r_state == S_GAP && r_cnt == 8'(BIT_CYCLES - 2);
        end else begin
            r_cnt    <= '0;
            r_strobe <= 1'b1;
            r_done   <= 1'b0;
            case (r_state)
                S_SYNC: begin
                    r_bit <= r_bit == 6'd3 ? '0 : r_bit + 6'd1;
                    r_out <= r_bit == 6'd3 ? r_shift[DATA_W-1] : r_bit[0];
                    if (r_bit == 6'd3) r_state <= S_DATA;
                end
                S_DATA: begin
                    if (r_bit == 6'(DATA_W - 1)) begin
                        r_state <= S_PARITY;
                        r_out   <= r_par;
                    end else begin
                        r_bit   <= r_bit + 6'd1;
                        r_shift <= w_shl;
                        r_out   <= w_shl[DATA_W-1];
                    end
                end
                S_PARITY: begin
                    r_state  <= S_GAP;
                    r_out    <= 1'b0;
                    r_active <= 1'b0;
                    r_strobe <= 1'b0;
                    r_done   <= BIT_CYCLES == 1;
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_strobe <= 1'b0;
                    r_ready  <= 1'b1;
                end
            endcase
        end
    end
endmodule
